// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one uart_tx between N_REQ byte-stream requesters,
// holding each grant until the requester's "last" byte has left the line.
// Optional idle-grant timeout: define UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int N_REQ        = 4,
  parameter int TIMEOUT_CLKS = 65535
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst_n,
  input  logic [N_REQ-1:0]     i_Req_Valid,
  input  logic [N_REQ-1:0]     i_Req_Last,
  input  logic [8*N_REQ-1:0]   i_Req_Byte,
  output logic [N_REQ-1:0]     o_Req_Ready,
  output logic [N_REQ-1:0]     o_Grant,
  output logic                 o_Tx_DV,
  output logic [7:0]           o_Tx_Byte,
  input  logic                 i_Tx_Active,
  input  logic                 i_Tx_Done,
  output logic                 o_Busy,
  output logic                 o_Timeout,
  output logic [2:0]           o_Dbg_State
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  // Requester handshake: a byte moves when Valid[r] & Ready[r] are both high at a
  // rising clock edge; Ready is only ever raised for the granted requester in LOAD.
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_ISSUE     = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_DRAIN     = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [7:0]       byte_q, byte_d;
  logic             last_q, last_d;
  logic             timeout_q, timeout_d;

  logic             win_found;
  logic [PW-1:0]    win_idx;
  logic [PW-1:0]    cand;
  logic             uart_quiet;
  logic             cur_valid;
  logic             cur_last;
  logic [7:0]       cur_byte;
  logic             to_hit;

  assign uart_quiet = !i_Tx_Active && !i_Tx_Done;

  // While granted, ptr_q always names the owner, so it doubles as the select.
  assign cur_valid = i_Req_Valid[ptr_q];
  assign cur_last  = i_Req_Last[ptr_q];
  assign cur_byte  = i_Req_Byte[{ptr_q, 3'b000} +: 8];

  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    cand      = ptr_q;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = PW'((int'(ptr_q) + i) % N_REQ);
      if (!win_found && i_Req_Valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;

  // Counts only while waiting in LOAD; any other state leaves it cleared for the next entry.
  always_comb begin
    cnt_d = '0;
    if (state_q == S_LOAD && !cur_valid) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign to_hit = (state_q == S_LOAD) && !cur_valid && (cnt_q == 16'(TIMEOUT_CLKS - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CLKS == 0);
  assign to_hit             = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    byte_d    = byte_q;
    last_d    = last_q;
    timeout_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (uart_quiet && win_found) begin
          grant_d = N_REQ'(1) << win_idx;
          ptr_d   = win_idx;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (cur_valid) begin
          byte_d  = cur_byte;
          last_d  = cur_last;
          state_d = S_ISSUE;
        end else if (to_hit) begin
          // Pointer stays on the revoked owner so everyone else is searched first.
          grant_d   = '0;
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (i_Tx_Done) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (!i_Tx_Done) begin
          if (last_q) begin
            grant_d = '0;
            state_d = S_IDLE;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      default: begin
        grant_d = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q   <= S_IDLE;
      ptr_q     <= PW'(N_REQ - 1);
      grant_q   <= '0;
      byte_q    <= '0;
      last_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      byte_q    <= byte_d;
      last_q    <= last_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_Req_Ready = (state_q == S_LOAD) ? grant_q : '0;
  assign o_Grant     = grant_q;
  assign o_Tx_DV     = (state_q == S_ISSUE);
  assign o_Tx_Byte   = byte_q;
  assign o_Busy      = |grant_q;
  assign o_Timeout   = timeout_q;
  assign o_Dbg_State = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: behavioural uart_tx (4 clocks/bit), serial decoder,
// table-driven arbitration vectors, corner sequences and randomized packet rounds.
module tb_uart_tx_arbiter;
  localparam int N   = 4;
  localparam int CPB = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid, req_last, rdy, grant;
  logic [8*N-1:0] req_byte;
  logic           tx_dv, tx_active, tx_done, busy, timeout, tx_line;
  logic [7:0]     tx_byte;
  logic [2:0]     dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx_arbiter #(.N_REQ(N), .TIMEOUT_CLKS(16)) dut (
    .i_Clock(clk), .i_Rst_n(rst_n),
    .i_Req_Valid(req_valid), .i_Req_Last(req_last), .i_Req_Byte(req_byte),
    .o_Req_Ready(rdy), .o_Grant(grant), .o_Tx_DV(tx_dv), .o_Tx_Byte(tx_byte),
    .i_Tx_Active(tx_active), .i_Tx_Done(tx_done), .o_Busy(busy),
    .o_Timeout(timeout), .o_Dbg_State(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard storage ----------------
  logic [3:0] obs_g[$];
  logic [7:0] obs_b[$];
  logic [7:0] line_q[$];
  logic [3:0] exp_g[$];
  logic [7:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- requester driver ----------------
  logic [8:0] dmem[N][64];
  int         d_wr[N];
  int         d_rd[N];

  task automatic push_req(input int r, input logic last, input logic [7:0] b);
    dmem[r][d_wr[r]] = {last, b};
    d_wr[r]++;
  endtask

  initial begin
    logic [N-1:0] fire;
    req_valid = '0;
    req_last  = '0;
    req_byte  = '0;
    for (int r = 0; r < N; r++) begin
      d_wr[r] = 0;
      d_rd[r] = 0;
    end
    forever begin
      @(negedge clk);
      fire = req_valid & rdy;
      @(posedge clk);
      #1;
      for (int r = 0; r < N; r++) begin
        if (fire[r]) d_rd[r]++;
        if (d_rd[r] < d_wr[r]) begin
          req_valid[r]        = 1'b1;
          req_last[r]         = dmem[r][d_rd[r]][8];
          req_byte[8*r +: 8]  = dmem[r][d_rd[r]][7:0];
        end else begin
          req_valid[r] = 1'b0;
          req_last[r]  = 1'b0;
        end
      end
    end
  end

  // ---------------- behavioural uart_tx ----------------
  initial begin
    logic [7:0] bv;
    tx_active = 1'b0;
    tx_done   = 1'b0;
    tx_line   = 1'b1;
    forever begin
      @(negedge clk);
      if (tx_dv) begin
        bv        = tx_byte;
        tx_active = 1'b1;
        for (int i = 0; i < 10; i++) begin
          tx_line = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : bv[i-1];
          repeat (CPB) @(negedge clk);
        end
        tx_active = 1'b0;
        tx_done   = 1'b1;
        repeat (2) @(negedge clk);
        tx_done   = 1'b0;
      end
    end
  end

  // ---------------- serial line decoder ----------------
  initial begin
    logic [7:0] d;
    logic [7:0] e;
    forever begin
      @(posedge clk);
      if (tx_line == 1'b0) begin
        repeat (CPB / 2) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(posedge clk);
          d[i] = tx_line;
        end
        repeat (CPB) @(posedge clk);
        chk("line_stop_bit", 32'(tx_line), 32'd1);
        if (line_q.size() == 0) begin
          chk("line_unexpected_frame", 32'd1, 32'd0);
        end else begin
          e = line_q.pop_front();
          chk("line_byte", 32'(d), 32'(e));
        end
      end
    end
  end

  // ---------------- per-cycle monitor ----------------
  initial begin
    logic prev_dv;
    prev_dv = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      chk("grant_onehot0", 32'($onehot0(grant)), 32'd1);
      chk("ready_within_grant", 32'((rdy & ~grant) == '0), 32'd1);
      chk("busy_vs_grant", 32'(busy), 32'(|grant));
`ifndef UART_TX_ARB_TIMEOUT_EN
      chk("timeout_tied0", 32'(timeout), 32'd0);
`endif
      if (tx_dv) begin
        chk("dv_uart_quiet", 32'(tx_active | tx_done), 32'd0);
        chk("dv_one_cycle", 32'(prev_dv), 32'd0);
        obs_g.push_back(grant);
        obs_b.push_back(tx_byte);
        line_q.push_back(tx_byte);
      end
      prev_dv = tx_dv;
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_obs(output logic [3:0] g, output logic [7:0] b, output bit ok);
    int n;
    n = 0;
    g = '0;
    b = '0;
    while (obs_b.size() == 0 && n < 3000) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (obs_b.size() == 0) begin
      ok = 1'b0;
      chk("dv_wait_expired", 32'd0, 32'd1);
    end else begin
      ok = 1'b1;
      g  = obs_g.pop_front();
      b  = obs_b.pop_front();
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((grant != '0 || tx_active || tx_done) && n < 3000) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("idle_wait", 32'(n < 3000), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus tables ----------------
  typedef struct {
    int         grp;
    int         req;
    logic [7:0] data;
    logic       last;
    logic [3:0] exp_grant;
  } vec_t;

  vec_t vecs[11];

  initial begin
    logic [3:0] g;
    logic [7:0] b;
    bit         ok;
    logic [8:0] rq_data[N][12];
    int         rq_n[N];
    int         pos[N];
    int         ptr, found, npk, len, n;
    logic [8:0] e;

    // Table order is the expected service order within each group.
    vecs[0]  = '{0, 0, 8'h10, 1'b1, 4'b0001};
    vecs[1]  = '{0, 1, 8'h21, 1'b1, 4'b0010};
    vecs[2]  = '{0, 2, 8'h32, 1'b1, 4'b0100};
    vecs[3]  = '{0, 3, 8'h43, 1'b1, 4'b1000};
    vecs[4]  = '{1, 1, 8'h41, 1'b0, 4'b0010};
    vecs[5]  = '{1, 1, 8'h42, 1'b0, 4'b0010};
    vecs[6]  = '{1, 1, 8'h43, 1'b1, 4'b0010};
    vecs[7]  = '{1, 2, 8'h55, 1'b1, 4'b0100};
    vecs[8]  = '{2, 3, 8'h60, 1'b1, 4'b1000};
    vecs[9]  = '{2, 0, 8'h70, 1'b1, 4'b0001};
    vecs[10] = '{2, 3, 8'h61, 1'b1, 4'b1000};

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_ready", 32'(rdy), 32'd0);
    chk("rst_dv", 32'(tx_dv), 32'd0);
    chk("rst_byte", 32'(tx_byte), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_state_idle", 32'(dbg_state), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven arbitration groups
    for (int grp = 0; grp < 3; grp++) begin
      wait_idle();
      for (int i = 0; i < 11; i++)
        if (vecs[i].grp == grp) push_req(vecs[i].req, vecs[i].last, vecs[i].data);
      for (int i = 0; i < 11; i++) begin
        if (vecs[i].grp == grp) begin
          wait_obs(g, b, ok);
          if (ok) begin
            chk("tbl_grant", 32'(g), 32'(vecs[i].exp_grant));
            chk("tbl_byte", 32'(b), 32'(vecs[i].data));
          end
        end
      end
    end

    // Reset in the middle of a frame
    wait_idle();
    push_req(0, 1'b1, 8'h80);
    wait_obs(g, b, ok);
    if (ok) chk("pre_rst_byte", 32'(b), 32'h80);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_grant", 32'(grant), 32'd0);
    chk("midrst_ready", 32'(rdy), 32'd0);
    chk("midrst_dv", 32'(tx_dv), 32'd0);
    chk("midrst_byte", 32'(tx_byte), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_timeout", 32'(timeout), 32'd0);
    push_req(0, 1'b1, 8'h81);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_obs(g, b, ok);
    if (ok) begin
      chk("postrst_grant", 32'(g), 32'b0001);
      chk("postrst_byte", 32'(b), 32'h81);
    end

    // Owner stalls after a non-last byte
    wait_idle();
    push_req(2, 1'b0, 8'h90);
    push_req(3, 1'b1, 8'h91);
    wait_obs(g, b, ok);
    if (ok) begin
      chk("stall_grant", 32'(g), 32'b0100);
      chk("stall_byte", 32'(b), 32'h90);
    end
`ifdef UART_TX_ARB_TIMEOUT_EN
    n = 0;
    while (!tx_done && n < 200) begin @(posedge clk); #2; n++; end
    n = 0;
    while (tx_done && n < 200) begin @(posedge clk); #2; n++; end
    n = 0;
    while (!timeout && n < 100) begin @(posedge clk); #2; n++; end
    chk("timeout_load_cycles", 32'(n), 32'd16);
    chk("timeout_grant", 32'(grant), 32'd0);
    @(posedge clk);
    #2;
    chk("timeout_one_cycle", 32'(timeout), 32'd0);
    wait_obs(g, b, ok);
    if (ok) begin
      chk("after_to_grant", 32'(g), 32'b1000);
      chk("after_to_byte", 32'(b), 32'h91);
    end
`else
    n = 0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      #2;
      if (grant == 4'b0100 && !tx_dv) n++;
    end
    chk("hold_cycles", 32'(n), 32'd1000);
    chk("hold_no_dv", 32'(obs_b.size()), 32'd0);
    push_req(2, 1'b1, 8'h92);
    wait_obs(g, b, ok);
    if (ok) begin
      chk("resume_grant", 32'(g), 32'b0100);
      chk("resume_byte", 32'(b), 32'h92);
    end
    wait_obs(g, b, ok);
    if (ok) begin
      chk("next_grant", 32'(g), 32'b1000);
      chk("next_byte", 32'(b), 32'h91);
    end
`endif

    // Randomized rounds against a round-robin packet model
    for (int round = 0; round < 3; round++) begin
      wait_idle();
      chk("no_stray_dv", 32'(obs_b.size()), 32'd0);
      do_reset();
      for (int r = 0; r < N; r++) begin
        rq_n[r] = 0;
        pos[r]  = 0;
        npk     = $urandom_range(1, 3);
        for (int k = 0; k < npk; k++) begin
          len = $urandom_range(1, 3);
          for (int j = 0; j < len; j++) begin
            rq_data[r][rq_n[r]] = {(j == len - 1), 8'($urandom_range(0, 255))};
            rq_n[r]++;
          end
        end
      end
      ptr = N - 1;
      forever begin
        found = -1;
        for (int i = 1; i <= N; i++)
          if (found < 0 && pos[(ptr + i) % N] < rq_n[(ptr + i) % N]) found = (ptr + i) % N;
        if (found < 0) break;
        do begin
          e = rq_data[found][pos[found]];
          pos[found]++;
          exp_g.push_back(4'(1 << found));
          exp_q.push_back(e[7:0]);
        end while (!e[8]);
        ptr = found;
      end
      for (int r = 0; r < N; r++)
        for (int k = 0; k < rq_n[r]; k++) push_req(r, rq_data[r][k][8], rq_data[r][k][7:0]);
      while (exp_q.size() > 0) begin
        wait_obs(g, b, ok);
        if (!ok) break;
        chk("rand_grant", 32'(g), 32'(exp_g.pop_front()));
        chk("rand_byte", 32'(b), 32'(exp_q.pop_front()));
      end
      exp_g.delete();
      exp_q.delete();
    end

    wait_idle();
    repeat (60) @(posedge clk);
    chk("line_backlog", 32'(line_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart_tx transmitter between N_REQ byte-stream requesters.
- Uses round-robin arbitration with packet atomicity: a grant is held until the requester's byte flagged "last" has fully left the line.
- Sits between the requester blocks (console/debug/status sources) and the uart_tx instance.
- Drives uart_tx i_Tx_DV/i_Tx_Byte and sequences on its o_Tx_Active/o_Tx_Done.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- TIMEOUT_CLKS, 65535, idle-grant timeout in clocks (used only with the optional feature; max 65535, 16-bit counter).

Ports:
- i_Clock  in  1  system clock.
- i_Rst_n  in  1  reset, asynchronous, active-low.
- i_Req_Valid  in  N_REQ  requester r presents a byte.
- i_Req_Last  in  N_REQ  byte is the last of the requester's packet.
- i_Req_Byte  in  8*N_REQ  byte for requester r at bits [8r+7:8r].
- o_Req_Ready  out  N_REQ  byte accepted this cycle when Valid&Ready.
- o_Grant  out  N_REQ  one-hot current owner; all-zero when free.
- o_Tx_DV  out  1  one-cycle start pulse to uart_tx.
- o_Tx_Byte  out  8  byte to uart_tx, stable from the DV pulse until the next accept.
- i_Tx_Active  in  1  from uart_tx.
- i_Tx_Done  in  1  from uart_tx; high for 2 cycles at frame end.
- o_Busy  out  1  o_Grant != 0.
- o_Timeout  out  1  one-cycle pulse when a grant is revoked by timeout (optional feature only; otherwise tied 0).

Behaviour:
- Reset (async assert, sync release):
  - o_Grant=0, o_Req_Ready=0, o_Tx_DV=0, o_Tx_Byte=0, o_Busy=0, o_Timeout=0.
  - RR pointer=N_REQ-1, so requester 0 has first priority. State=IDLE.
- Mid-frame reset: the arbiter stays in IDLE until the UART is quiet (i_Tx_Active=0 and i_Tx_Done=0), so an in-flight frame is never overlapped.
- IDLE:
  - If the UART is quiet and any i_Req_Valid is set, grant the first valid requester searching from ptr+1 upward with wrap.
  - Register o_Grant and ptr := winner, then go to LOAD.
  - Valid bits that drop before the grant are ignored; Valid is not required to be sticky.
- LOAD:
  - o_Req_Ready = o_Grant (combinational, LOAD only).
  - On Valid[g]: latch Byte[g] into o_Tx_Byte and Last[g] into last_r, then go to ISSUE.
  - The grant is held while Valid[g] is low, including indefinitely unless the optional feature is enabled.
- ISSUE:
  - o_Tx_DV=1 for exactly this one cycle (the cycle after accept).
  - Go to WAIT_DONE.
- WAIT_DONE:
  - Wait for i_Tx_Done=1, then go to DRAIN.
- DRAIN:
  - Wait for i_Tx_Done=0 (the UART is back in its IDLE state).
  - If last_r=1: o_Grant := 0 and go to IDLE.
  - If last_r=0: go to LOAD with the grant unchanged.
- Throughput: accept-to-DV is 1 clock. Accepts for back-to-back bytes are 10*CLKS_PER_BIT+4 clocks apart minimum (DRAIN exit → LOAD accept → ISSUE).
- Requests from non-granted requesters never see Ready. A requester keeps its RR position until it is served.
- Single requester: it is re-granted after each packet with 1 IDLE cycle between packets.
- At most one of o_Req_Ready bits is set; o_Grant is always zero or one-hot (assertion targets).

Optional Feature:
- Macro: UART_TX_ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit counter runs in LOAD, cleared on entry to LOAD and on accept.
  - If the counter reaches TIMEOUT_CLKS-1 with Valid[g]=0: o_Grant := 0, o_Timeout pulses 1 cycle, go to IDLE. The RR pointer stays at the revoked requester, so others get priority.
  - Partial packets are abandoned; already-sent bytes are not recalled.
- Not defined:
  - No counter logic; o_Timeout tied 0.
  - The grant is held in LOAD indefinitely.

Test Plan:
- All 4 requesters assert Valid with 1-byte packets (Last=1, bytes 0x10,0x21,0x32,0x43) from reset → service order 0,1,2,3. Each o_Tx_DV is a 1-cycle pulse with the matching byte, and no DV occurs while i_Tx_Active=1.
- Req 1 sends a 3-byte packet 0x41,0x42,0x43 (Last on the 3rd) while req 2 is Valid throughout → o_Grant stays 4'b0010 across all 3 bytes, then becomes 4'b0100. The line shows 41,42,43 then req 2's byte.
- Round-robin fairness: after req 3 is served with reqs 0 and 3 both Valid → req 0 is granted next, not req 3.
- Reset asserted mid-frame while the uart_tx model is still Active: all outputs go 0 immediately. After release with Req 0 Valid, no o_Tx_DV occurs until Active=0 and Done=0.
- Uart_tx instance with CLKS_PER_BIT=4 driven by the arbiter; a serial checker decodes the line → byte stream matches the arbitration order exactly, with no truncated frames.
- With UART_TX_ARB_TIMEOUT_EN and TIMEOUT_CLKS=16, req 2 sends a non-last byte then drops Valid → at 16 clocks in LOAD o_Timeout pulses and o_Grant=0. Req 3 (Valid) is granted next; without the macro the grant holds beyond 1000 clocks.
